// File: rtl/axi_aw_xbar_rr.sv
// AXI write-address crossbar: round-robin master arbitration, address decode to
// NUM_S slaves plus a default slave, one-entry output slice and a W-route FIFO.
module axi_aw_xbar_rr #(
    parameter int unsigned NUM_M    = 3,
    parameter int unsigned NUM_S    = 7,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MIDX_W   = $clog2(NUM_M),
    parameter int unsigned SIDX_W   = $clog2(NUM_S + 1),
    parameter int unsigned IDS_W    = ID_W + MIDX_W,
    parameter logic [NUM_S*16-1:0] ADDR_MAP = '0,
    parameter int unsigned RT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M*ID_W-1:0]    id_m_i,
    input  logic [NUM_M*ADDR_W-1:0]  addr_m_i,
    input  logic [NUM_M*8-1:0]       len_m_i,
    input  logic [NUM_M*3-1:0]       size_m_i,
    input  logic [NUM_M*2-1:0]       burst_m_i,
    input  logic [NUM_M-1:0]         valid_m_i,
    output logic [NUM_M-1:0]         ready_m_o,
    output logic [IDS_W-1:0]         id_s_o,
    output logic [ADDR_W-1:0]        addr_s_o,
    output logic [7:0]               len_s_o,
    output logic [2:0]               size_s_o,
    output logic [1:0]               burst_s_o,
    output logic [NUM_S:0]           valid_s_o,
    input  logic [NUM_S:0]           ready_s_i,
    output logic                     rt_valid_o,
    output logic [MIDX_W-1:0]        rt_mst_o,
    output logic [SIDX_W-1:0]        rt_slv_o,
    input  logic                     rt_pop_i
);

    localparam int unsigned PTR_W = $clog2(RT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [MIDX_W-1:0] r_ptr;

    logic              r_full;
    logic [SIDX_W-1:0] r_slv;
    logic [IDS_W-1:0]  r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;

    logic [MIDX_W-1:0] r_rt_mst [RT_DEPTH];
    logic [SIDX_W-1:0] r_rt_slv [RT_DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic [MIDX_W-1:0] w_grant;
    logic              w_any_valid;
    logic [ID_W-1:0]   w_g_id;
    logic [ADDR_W-1:0] w_g_addr;
    logic [7:0]        w_g_len;
    logic [2:0]        w_g_size;
    logic [1:0]        w_g_burst;
    logic [SIDX_W-1:0] w_slv;
    logic [NUM_S:0]    w_valid_s;
    logic              w_drain;
    logic              w_rt_empty;
    logic              w_pop;
    logic              w_rt_full;
    logic              w_acc;

    // Round-robin: the valid master at the smallest circular distance from r_ptr wins.
    always_comb begin : arb
        int v_best;
        int v_dist;
        w_grant = '0;
        v_best  = int'(NUM_M);
        v_dist  = 0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            v_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + int'(NUM_M) - int'(r_ptr));
            if (valid_m_i[i] && (v_dist < v_best)) begin
                v_best  = v_dist;
                w_grant = MIDX_W'(i);
            end
        end
    end

    assign w_any_valid = |valid_m_i;

    // Granted master payload mux.
    always_comb begin
        w_g_id    = '0;
        w_g_addr  = '0;
        w_g_len   = '0;
        w_g_size  = '0;
        w_g_burst = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (w_grant == MIDX_W'(i)) begin
                w_g_id    = id_m_i[i*ID_W +: ID_W];
                w_g_addr  = addr_m_i[i*ADDR_W +: ADDR_W];
                w_g_len   = len_m_i[i*8 +: 8];
                w_g_size  = size_m_i[i*3 +: 3];
                w_g_burst = burst_m_i[i*2 +: 2];
            end
        end
    end

    // Decode: descending scan so the lowest matching tag wins; no match selects DS.
    always_comb begin
        w_slv = SIDX_W'(NUM_S);
        for (int k = int'(NUM_S) - 1; k >= 0; k--) begin
            if (w_g_addr[ADDR_W-1 -: 16] == ADDR_MAP[k*16 +: 16]) begin
                w_slv = SIDX_W'(k);
            end
        end
    end

    always_comb begin
        w_valid_s = '0;
        for (int s = 0; s <= int'(NUM_S); s++) begin
            w_valid_s[s] = r_full && (r_slv == SIDX_W'(s));
        end
    end

    assign w_drain    = |(w_valid_s & ready_s_i);
    assign w_rt_empty = (r_cnt == '0);
    assign w_pop      = rt_pop_i & ~w_rt_empty;
    // A pop in the same cycle frees the slot a push needs.
    assign w_rt_full  = (r_cnt == CNT_W'(RT_DEPTH)) & ~w_pop;
    // rst gating keeps AWREADY low while reset is held, not just after an edge.
    assign w_acc      = rst & w_any_valid & (~r_full | w_drain) & ~w_rt_full;

    always_comb begin
        ready_m_o = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            ready_m_o[i] = w_acc && (w_grant == MIDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= (w_grant == MIDX_W'(NUM_M - 1)) ? '0 : (w_grant + MIDX_W'(1));
        end
    end

    // Output slice: load on accept (may coincide with drain), else empty on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full  <= 1'b0;
            r_slv   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (w_acc) begin
            r_full  <= 1'b1;
            r_slv   <= w_slv;
            r_id    <= {w_grant, w_g_id};
            r_addr  <= w_g_addr;
            r_len   <= w_g_len;
            r_size  <= w_g_size;
            r_burst <= w_g_burst;
        end else if (w_drain) begin
            r_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int d = 0; d < int'(RT_DEPTH); d++) begin
                r_rt_mst[d] <= '0;
                r_rt_slv[d] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_rt_mst[r_wr] <= w_grant;
                r_rt_slv[r_wr] <= w_slv;
                r_wr           <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign valid_s_o  = w_valid_s;
    assign id_s_o     = r_id;
    assign addr_s_o   = r_addr;
    assign len_s_o    = r_len;
    assign size_s_o   = r_size;
    assign burst_s_o  = r_burst;
    assign rt_valid_o = ~w_rt_empty;
    assign rt_mst_o   = w_rt_empty ? '0 : r_rt_mst[r_rd];
    assign rt_slv_o   = w_rt_empty ? '0 : r_rt_slv[r_rd];

endmodule

// File: tb/tb_axi_aw_xbar_rr.sv
// Directed bench for axi_aw_xbar_rr: 3 masters, 7 slaves (slave k tag = k), DS = 7.
module tb_axi_aw_xbar_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] id_m_i;
    logic [95:0] addr_m_i;
    logic [23:0] len_m_i;
    logic [8:0]  size_m_i;
    logic [5:0]  burst_m_i;
    logic [2:0]  valid_m_i;
    logic [2:0]  ready_m_o;
    logic [5:0]  id_s_o;
    logic [31:0] addr_s_o;
    logic [7:0]  len_s_o;
    logic [2:0]  size_s_o;
    logic [1:0]  burst_s_o;
    logic [7:0]  valid_s_o;
    logic [7:0]  ready_s_i;
    logic        rt_valid_o;
    logic [1:0]  rt_mst_o;
    logic [2:0]  rt_slv_o;
    logic        rt_pop_i;

    logic [3:0]  m_id   [3];
    logic [31:0] m_addr [3];
    logic [7:0]  m_len  [3];
    logic [2:0]  m_valid;

    int checks = 0;
    int passed = 0;

    axi_aw_xbar_rr #(
        .NUM_M(3), .NUM_S(7), .ID_W(4), .ADDR_W(32), .RT_DEPTH(4),
        .ADDR_MAP({16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000})
    ) dut (
        .clk(clk), .rst(rst),
        .id_m_i(id_m_i), .addr_m_i(addr_m_i), .len_m_i(len_m_i),
        .size_m_i(size_m_i), .burst_m_i(burst_m_i),
        .valid_m_i(valid_m_i), .ready_m_o(ready_m_o),
        .id_s_o(id_s_o), .addr_s_o(addr_s_o), .len_s_o(len_s_o),
        .size_s_o(size_s_o), .burst_s_o(burst_s_o),
        .valid_s_o(valid_s_o), .ready_s_i(ready_s_i),
        .rt_valid_o(rt_valid_o), .rt_mst_o(rt_mst_o), .rt_slv_o(rt_slv_o),
        .rt_pop_i(rt_pop_i)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            id_m_i[i*4 +: 4]    = m_id[i];
            addr_m_i[i*32 +: 32] = m_addr[i];
            len_m_i[i*8 +: 8]   = m_len[i];
            size_m_i[i*3 +: 3]  = 3'd2;
            burst_m_i[i*2 +: 2] = 2'b01;
        end
        valid_m_i = m_valid;
    end

    task automatic clear_m();
        for (int i = 0; i < 3; i++) begin
            m_id[i]   = 4'h0;
            m_addr[i] = 32'h0;
            m_len[i]  = 8'h0;
        end
        m_valid = 3'b000;
    endtask

    // Ends just after a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b0;
        clear_m();
        ready_s_i = 8'hFF;
        rt_pop_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_m();
        ready_s_i = 8'hFF;
        rt_pop_i  = 1'b0;
        #1;
        checks++; if (valid_s_o !== 8'h00) $display("FAIL reset_valid_s got %h exp 00", valid_s_o); else passed++;
        checks++; if (ready_m_o !== 3'b000) $display("FAIL reset_ready_m got %b exp 000", ready_m_o); else passed++;
        checks++; if (rt_valid_o !== 1'b0) $display("FAIL reset_rt_valid got %b exp 0", rt_valid_o); else passed++;
        checks++; if ({rt_mst_o, rt_slv_o} !== 5'h00) $display("FAIL reset_rt_head got %h exp 00", {rt_mst_o, rt_slv_o}); else passed++;
        checks++; if ({id_s_o, addr_s_o, len_s_o} !== 46'h0) $display("FAIL reset_payload got %h exp 0", {id_s_o, addr_s_o, len_s_o}); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        clear_m();
        m_addr[1] = 32'h0001_0040; m_id[1] = 4'h3; m_len[1] = 8'd3; m_valid[1] = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b010) $display("FAIL single_ready got %b exp 010", ready_m_o); else passed++;
        @(negedge clk);
        m_valid = 3'b000;
        #1;
        checks++; if (valid_s_o !== 8'b0000_0010) $display("FAIL single_valid_s got %b exp 00000010", valid_s_o); else passed++;
        checks++; if (id_s_o !== 6'h13) $display("FAIL single_id got %h exp 13", id_s_o); else passed++;
        checks++; if (addr_s_o !== 32'h0001_0040) $display("FAIL single_addr got %h exp 00010040", addr_s_o); else passed++;
        checks++; if (len_s_o !== 8'd3) $display("FAIL single_len got %0d exp 3", len_s_o); else passed++;
        checks++; if ({rt_valid_o, rt_mst_o, rt_slv_o} !== {1'b1, 2'd1, 3'd1}) $display("FAIL single_route got %b exp 1_01_001", {rt_valid_o, rt_mst_o, rt_slv_o}); else passed++;
        @(negedge clk);
        #1;
        checks++; if (valid_s_o !== 8'h00) $display("FAIL single_drain got %h exp 00", valid_s_o); else passed++;
        rt_pop_i = 1'b1;
        @(negedge clk);
        rt_pop_i = 1'b0;
        #1;
        checks++; if (rt_valid_o !== 1'b0) $display("FAIL single_pop got %b exp 0", rt_valid_o); else passed++;
    endtask

    // Pointer is 2 here, so lone M0 is reached by wrapping.
    task automatic test_default();
        clear_m();
        m_addr[0] = 32'hDEAD_0000; m_id[0] = 4'h5; m_valid[0] = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b001) $display("FAIL ds_ready got %b exp 001", ready_m_o); else passed++;
        @(negedge clk);
        m_valid = 3'b000;
        #1;
        checks++; if (valid_s_o !== 8'h80) $display("FAIL ds_valid_s got %h exp 80", valid_s_o); else passed++;
        checks++; if (rt_slv_o !== 3'd7) $display("FAIL ds_rt_slv got %0d exp 7", rt_slv_o); else passed++;
        checks++; if (rt_mst_o !== 2'd0) $display("FAIL ds_rt_mst got %0d exp 0", rt_mst_o); else passed++;
        checks++; if (id_s_o !== 6'h05) $display("FAIL ds_id got %h exp 05", id_s_o); else passed++;
        rt_pop_i = 1'b1;
        @(negedge clk);
        rt_pop_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        logic [7:0] exp_vs;
        do_reset();
        for (int i = 0; i < 3; i++) m_addr[i] = {16'(i), 16'h0100};
        m_valid  = 3'b111;
        rt_pop_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 3'b001 << (c % 3);
            checks++; if (ready_m_o !== exp_rdy) $display("FAIL rr_ready c=%0d got %b exp %b", c, ready_m_o, exp_rdy); else passed++;
            if (c > 0) begin
                exp_vs = 8'h01 << ((c - 1) % 3);
                checks++; if (valid_s_o !== exp_vs) $display("FAIL rr_valid_s c=%0d got %b exp %b", c, valid_s_o, exp_vs); else passed++;
                checks++; if (rt_mst_o !== 2'((c - 1) % 3)) $display("FAIL rr_rt_mst c=%0d got %0d exp %0d", c, rt_mst_o, (c - 1) % 3); else passed++;
            end
            @(negedge clk);
        end
        m_valid = 3'b000;
        #1;
        checks++; if (valid_s_o !== 8'h04) $display("FAIL rr_last got %h exp 04", valid_s_o); else passed++;
        @(negedge clk);
        @(negedge clk);
        rt_pop_i = 1'b0;
        #1;
        checks++; if (rt_valid_o !== 1'b0) $display("FAIL rr_rt_empty got %b exp 0", rt_valid_o); else passed++;
    endtask

    task automatic test_backpressure();
        clear_m();
        ready_s_i = 8'hFB;
        m_addr[2] = 32'h0002_0010; m_id[2] = 4'h7; m_len[2] = 8'd1; m_valid[2] = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b100) $display("FAIL bp_first_ready got %b exp 100", ready_m_o); else passed++;
        @(negedge clk);
        m_addr[2] = 32'h0002_0020; m_id[2] = 4'h9;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (valid_s_o !== 8'h04) $display("FAIL bp_valid_s k=%0d got %h exp 04", k, valid_s_o); else passed++;
            checks++; if ({id_s_o, addr_s_o} !== {6'h27, 32'h0002_0010}) $display("FAIL bp_payload k=%0d got %h exp 2700020010", k, {id_s_o, addr_s_o}); else passed++;
            checks++; if (ready_m_o !== 3'b000) $display("FAIL bp_ready k=%0d got %b exp 000", k, ready_m_o); else passed++;
            @(negedge clk);
        end
        ready_s_i = 8'hFF;
        #1;
        checks++; if (ready_m_o !== 3'b100) $display("FAIL bp_release_ready got %b exp 100", ready_m_o); else passed++;
        @(negedge clk);
        m_valid = 3'b000;
        #1;
        checks++; if ({valid_s_o, id_s_o, addr_s_o} !== {8'h04, 6'h29, 32'h0002_0020}) $display("FAIL bp_second got %h exp 042900020020", {valid_s_o, id_s_o, addr_s_o}); else passed++;
        rt_pop_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rt_pop_i = 1'b0;
        #1;
        checks++; if ({valid_s_o, rt_valid_o} !== 9'h0) $display("FAIL bp_cleanup got %h exp 000", {valid_s_o, rt_valid_o}); else passed++;
    endtask

    task automatic test_route_full();
        logic [1:0] exp_m [4];
        logic [2:0] exp_s [4];
        logic [2:0] exp_rdy;
        exp_m = '{2'd1, 2'd2, 2'd0, 2'd1};
        exp_s = '{3'd1, 3'd2, 3'd3, 3'd5};
        for (int i = 0; i < 4; i++) begin
            clear_m();
            m_addr[i % 3]  = {16'(i), 16'h0000};
            m_valid[i % 3] = 1'b1;
            #1;
            exp_rdy = 3'b001 << (i % 3);
            checks++; if (ready_m_o !== exp_rdy) $display("FAIL rt_fill i=%0d got %b exp %b", i, ready_m_o, exp_rdy); else passed++;
            @(negedge clk);
        end
        clear_m();
        m_addr[1] = 32'h0005_0000; m_valid[1] = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b000) $display("FAIL rt_full_stall0 got %b exp 000", ready_m_o); else passed++;
        checks++; if ({rt_valid_o, rt_mst_o, rt_slv_o} !== 6'b1_00_000) $display("FAIL rt_full_head got %b exp 100000", {rt_valid_o, rt_mst_o, rt_slv_o}); else passed++;
        @(negedge clk);
        #1;
        checks++; if (ready_m_o !== 3'b000) $display("FAIL rt_full_stall1 got %b exp 000", ready_m_o); else passed++;
        rt_pop_i = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b010) $display("FAIL rt_pop_push_ready got %b exp 010", ready_m_o); else passed++;
        @(negedge clk);
        rt_pop_i = 1'b0;
        m_valid  = 3'b000;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++; if ({rt_valid_o, rt_mst_o, rt_slv_o} !== {1'b1, exp_m[j], exp_s[j]}) $display("FAIL rt_order j=%0d got %b exp %b", j, {rt_valid_o, rt_mst_o, rt_slv_o}, {1'b1, exp_m[j], exp_s[j]}); else passed++;
            rt_pop_i = 1'b1;
            @(negedge clk);
            rt_pop_i = 1'b0;
        end
        #1;
        checks++; if (rt_valid_o !== 1'b0) $display("FAIL rt_drained got %b exp 0", rt_valid_o); else passed++;
    endtask

    // Pointer is 2 on entry; two M0 grants leave it at 1 before reset.
    task automatic test_reset_midop();
        clear_m();
        ready_s_i = 8'hF7;
        m_addr[0] = 32'h0001_0000; m_valid[0] = 1'b1;
        #1;
        checks++; if (ready_m_o !== 3'b001) $display("FAIL mid_acc0 got %b exp 001", ready_m_o); else passed++;
        @(negedge clk);
        m_addr[0] = 32'h0003_0000;
        #1;
        checks++; if (ready_m_o !== 3'b001) $display("FAIL mid_acc1 got %b exp 001", ready_m_o); else passed++;
        @(negedge clk);
        m_addr[1] = 32'h0004_0000; m_addr[2] = 32'h0005_0000;
        m_valid = 3'b111;
        #1;
        checks++; if ({valid_s_o, ready_m_o, rt_valid_o} !== {8'h08, 3'b000, 1'b1}) $display("FAIL mid_setup got %b exp 00001000_000_1", {valid_s_o, ready_m_o, rt_valid_o}); else passed++;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (valid_s_o !== 8'h00) $display("FAIL mid_rst_valid_s got %h exp 00", valid_s_o); else passed++;
        checks++; if (rt_valid_o !== 1'b0) $display("FAIL mid_rst_rt_valid got %b exp 0", rt_valid_o); else passed++;
        checks++; if (ready_m_o !== 3'b000) $display("FAIL mid_rst_ready got %b exp 000", ready_m_o); else passed++;
        @(negedge clk);
        rst = 1'b1;
        ready_s_i = 8'hFF;
        #1;
        checks++; if (ready_m_o !== 3'b001) $display("FAIL mid_restart_grant got %b exp 001", ready_m_o); else passed++;
        @(negedge clk);
        m_valid = 3'b000;
        #1;
        checks++; if ({valid_s_o, rt_valid_o, rt_mst_o, rt_slv_o} !== {8'h08, 1'b1, 2'd0, 3'd3}) $display("FAIL mid_restart_out got %b exp 00001000_1_00_011", {valid_s_o, rt_valid_o, rt_mst_o, rt_slv_o}); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", checks, passed);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_default();
        test_round_robin();
        test_backpressure();
        test_route_full();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_aw_xbar_rr.md
Name: axi_aw_xbar_rr

Overview:
Parametrised AXI write-address crossbar for NUM_M masters and NUM_S decoded slaves plus one default slave (DS). Uses round-robin arbitration and a registered single-entry output slice. It also pushes a write-route FIFO that tells the W-channel mux which master/slave pair owns each upcoming write burst, in AW order. It replaces the fixed 3-master / 8-slave combinational AW path in the interconnect.

Parameters:
NUM_M, 3, number of masters (≥2)
NUM_S, 7, number of decoded slaves; DS is index NUM_S
ID_W, 4, master-side ID width
ADDR_W, 32, address width
MIDX_W, $clog2(NUM_M), master index width; IDS_W = ID_W+MIDX_W
SIDX_W, $clog2(NUM_S+1), slave index width
ADDR_MAP, {NUM_S{16'h0}}, packed NUM_S×16 tags; slave k owns addresses with addr[ADDR_W-1 -: 16] == ADDR_MAP[k*16+:16]
RT_DEPTH, 4, write-route FIFO depth (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_m_i  in  NUM_M*ID_W  per-master AWID, master i at slice i
addr_m_i  in  NUM_M*ADDR_W  per-master AWADDR
len_m_i  in  NUM_M*8  AWLEN
size_m_i  in  NUM_M*3  AWSIZE
burst_m_i  in  NUM_M*2  AWBURST
valid_m_i  in  NUM_M  AWVALID
ready_m_o  out  NUM_M  AWREADY
id_s_o  out  IDS_W  AWID to all slaves, {master idx, id}
addr_s_o  out  ADDR_W  shared AWADDR
len_s_o / size_s_o / burst_s_o  out  8/3/2  shared
valid_s_o  out  NUM_S+1  per-slave AWVALID, bit NUM_S = DS
ready_s_i  in  NUM_S+1  per-slave AWREADY
rt_valid_o  out  1  route FIFO non-empty
rt_mst_o  out  MIDX_W  head entry master index
rt_slv_o  out  SIDX_W  head entry slave index
rt_pop_i  in  1  W mux finished burst (WLAST handshake); pop head

Behaviour:
- Reset (rst=0, asynchronous): out slice empty, valid_s_o=0, ready_m_o=0, rr pointer=0, route FIFO empty (rt_valid_o=0, rt_mst_o=0, rt_slv_o=0). Payload outputs are 0.
- Decode (combinational on the granted master's addr): lowest k whose tag matches; no match → DS (index NUM_S).
- Arbitration: round-robin over valid_m_i starting at rr pointer. Grant g = first valid index ≥ ptr, wrapping. Grant is combinational each cycle.
- Accept condition acc = any valid & (slice empty | slice drains this cycle) & !rt_full.
- ready_m_o[g] = acc; all other bits are 0. ready_m_o never depends on the master's own valid except through the grant.
- On master handshake: the slice loads {g, id}, addr, len, size, burst and the decoded slave index. The rr pointer becomes (g+1) mod NUM_M. The route FIFO pushes {g, slave idx}.
- Latency: valid_s_o[slv] rises exactly 1 cycle after the master handshake. The slice holds payload stable until ready_s_i[slv]=1.
- Throughput: slice drain and new load in the same cycle are allowed, giving 1 AW per cycle sustained.
- Only the single addressed bit of valid_s_o is ever high. The shared payload is don't-care to unaddressed slaves.
- Route FIFO: RT_DEPTH entries, in-order.
  - Simultaneous push and pop when full: pop frees a slot, so push is allowed (rt_full is evaluated after pop). Same cycle as pop when full → accept.
  - Pop when empty is ignored.
  - Pointers wrap modulo RT_DEPTH. Count is tracked with a width-extended counter.
- Fairness: no master waits more than NUM_M−1 grants while continuously valid.
- A reset assertion mid-transfer drops the slice and the FIFO contents immediately. There is no recovery of in-flight AW.

Test Plan:
- Single write: M1 sends addr 0x0001_0040 with ADDR_MAP[1]=16'h0001, id 4'h3, len 3 → valid_s_o = 8'b0000_0010 one cycle after handshake; id_s_o={2'd1,4'h3}; route head {1,1}.
- Default slave: M0 sends addr 0xDEAD_0000 with no tag match → valid_s_o[7]=1, rt_slv_o=7.
- Round-robin: all 3 masters hold valid continuously and slaves are always ready → grant order 0,1,2,0,1,2; one acceptance per cycle; ready_m_o one-hot.
- Backpressure: ready_s_i[2]=0 for 5 cycles → valid_s_o[2] and payload stay stable; ready_m_o=0 throughout; first new accept in the cycle ready_s_i[2] returns.
- Route FIFO full: 4 AWs accepted with no rt_pop_i → 5th master stalls (ready_m_o=0). Asserting rt_pop_i alone gives acceptance that same cycle; rt_mst_o/rt_slv_o pop in push order.
- Reset mid-op: drop rst with slice full and FIFO count 2 → valid_s_o, rt_valid_o and ready_m_o are 0 in the same cycle (before any edge); after release, grant restarts at M0.
